// File: rtl/bcd_clock_24h_alarm.sv
// BCD hh:mm:ss time-of-day counter with 12h/24h display, range-checked time/alarm load,
// day-wrap strobe, alarm comparator and an optional enable prescaler.
module bcd_clock_24h_alarm #(
    parameter int unsigned TICK_DIV = 1,
    parameter bit          ALARM_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       mode_24h,
    input  logic       load,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic [7:0] ld_ss,
    input  logic       alarm_set,
    input  logic       alarm_arm,
    output logic       pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       load_err,
    output logic       day_wrap,
    output logic       alarm_hit
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt;
    logic [7:0]    h24;
    logic [7:0]    al_hh, al_mm, al_ss;
    logic [7:0]    hh_n, mm_n, ss_n;
    logic          wrap;
    logic          ld_ok, load_ok, tick;

    // BCD ordering matches binary ordering once both nibbles are decimal digits
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

    always_comb begin
        ld_ok   = bcd_ok(ld_hh, 8'h23) && bcd_ok(ld_mm, 8'h59) && bcd_ok(ld_ss, 8'h59);
        load_ok = load && ld_ok;
        tick    = ena && !load_ok && (pcnt == PLAST);
    end

    // Time plus one second, per-digit BCD carry
    always_comb begin
        hh_n = h24;
        mm_n = mm;
        ss_n = ss;
        wrap = 1'b0;
        if (ss[3:0] != 4'd9) begin
            ss_n[3:0] = 4'(ss[3:0] + 4'd1);
        end else if (ss[7:4] != 4'd5) begin
            ss_n = {4'(ss[7:4] + 4'd1), 4'h0};
        end else begin
            ss_n = 8'h00;
            if (mm[3:0] != 4'd9) begin
                mm_n[3:0] = 4'(mm[3:0] + 4'd1);
            end else if (mm[7:4] != 4'd5) begin
                mm_n = {4'(mm[7:4] + 4'd1), 4'h0};
            end else begin
                mm_n = 8'h00;
                if (h24 == 8'h23) begin
                    hh_n = 8'h00;
                    wrap = 1'b1;
                end else if (h24[3:0] == 4'd9) begin
                    hh_n = {4'(h24[7:4] + 4'd1), 4'h0};
                end else begin
                    hh_n[3:0] = 4'(h24[3:0] + 4'd1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt      <= '0;
            h24       <= 8'h00;
            mm        <= 8'h00;
            ss        <= 8'h00;
            al_hh     <= 8'h00;
            al_mm     <= 8'h00;
            al_ss     <= 8'h00;
            load_err  <= 1'b0;
            day_wrap  <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            load_err  <= !ld_ok && (load || (ALARM_EN && alarm_set));
            day_wrap  <= tick && wrap;
            alarm_hit <= ALARM_EN && tick && alarm_arm &&
                         ({hh_n, mm_n, ss_n} == {al_hh, al_mm, al_ss});
            if (load_ok) begin
                pcnt <= '0;
                h24  <= ld_hh;
                mm   <= ld_mm;
                ss   <= ld_ss;
            end else if (ena) begin
                pcnt <= (pcnt == PLAST) ? '0 : PW'(pcnt + PW'(1));
                if (tick) begin
                    h24 <= hh_n;
                    mm  <= mm_n;
                    ss  <= ss_n;
                end
            end
            // compares above use the alarm value held before this write
            if (ALARM_EN && alarm_set && ld_ok) begin
                al_hh <= ld_hh;
                al_mm <= ld_mm;
                al_ss <= ld_ss;
            end
        end
    end

    // 12h view: 00 -> 12 am, 13..23 -> 01..11 pm
    always_comb begin
        pm = (h24 >= 8'h12);
        hh = h24;
        if (!mode_24h) begin
            unique case (h24)
                8'h00:                                      hh = 8'h12;
                8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
                8'h19, 8'h22, 8'h23:                        hh = 8'(h24 - 8'h12);
                8'h20, 8'h21:                               hh = 8'(h24 - 8'h18);
                default:                                    hh = h24;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_clock_24h_alarm.sv
// Bench for bcd_clock_24h_alarm: two instances (TICK_DIV 1 and 3) against a
// seconds-of-day reference model, directed scenarios plus randomized traffic.
module tb_bcd_clock_24h_alarm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0, mode_24h = 1'b0, load = 1'b0, alarm_set = 1'b0, alarm_arm = 1'b0;
    logic [7:0] ld_hh = 8'h00, ld_mm = 8'h00, ld_ss = 8'h00;

    logic       o_pm[2], o_le[2], o_dw[2], o_ah[2];
    logic [7:0] o_hh[2], o_mm[2], o_ss[2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    bcd_clock_24h_alarm #(.TICK_DIV(1), .ALARM_EN(1'b1)) u1 (
        .clk(clk), .reset(rst), .ena(ena), .mode_24h(mode_24h), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .alarm_set(alarm_set),
        .alarm_arm(alarm_arm), .pm(o_pm[0]), .hh(o_hh[0]), .mm(o_mm[0]), .ss(o_ss[0]),
        .load_err(o_le[0]), .day_wrap(o_dw[0]), .alarm_hit(o_ah[0]));

    bcd_clock_24h_alarm #(.TICK_DIV(3), .ALARM_EN(1'b1)) u3 (
        .clk(clk), .reset(rst), .ena(ena), .mode_24h(mode_24h), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .alarm_set(alarm_set),
        .alarm_arm(alarm_arm), .pm(o_pm[1]), .hh(o_hh[1]), .mm(o_mm[1]), .ss(o_ss[1]),
        .load_err(o_le[1]), .day_wrap(o_dw[1]), .alarm_hit(o_ah[1]));

    // ---------------- reference model: time as seconds of day ----------------
    int m_t[2], m_al[2], m_cnt[2];
    bit m_le[2], m_dw[2], m_ah[2];
    int divs[2] = '{1, 3};

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int from_bcd(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit field_ok(input logic [7:0] b, input int lim);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (from_bcd(b) < lim);
    endfunction

    function automatic logic [7:0] exp_hh(input int t, input bit m24);
        int h, h12;
        h = t / 3600;
        if (m24) return to_bcd(h);
        h12 = h % 12;
        if (h12 == 0) h12 = 12;
        return to_bcd(h12);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_t[i] = 0; m_al[i] = 0; m_cnt[i] = 0;
                m_le[i] = 0; m_dw[i] = 0; m_ah[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit v, adv;
                int ld_sec, nt;
                v      = field_ok(ld_hh, 24) && field_ok(ld_mm, 60) && field_ok(ld_ss, 60);
                ld_sec = from_bcd(ld_hh) * 3600 + from_bcd(ld_mm) * 60 + from_bcd(ld_ss);
                adv    = 1'b0;
                m_le[i] = (load || alarm_set) && !v;
                m_dw[i] = 1'b0;
                m_ah[i] = 1'b0;
                if (load && v) begin
                    m_t[i] = ld_sec; m_cnt[i] = 0;
                end else if (ena) begin
                    if (m_cnt[i] == divs[i] - 1) begin
                        m_cnt[i] = 0; adv = 1'b1;
                    end else begin
                        m_cnt[i]++;
                    end
                end
                if (adv) begin
                    nt = (m_t[i] + 1) % 86400;
                    m_dw[i] = (nt == 0);
                    m_ah[i] = alarm_arm && (nt == m_al[i]);
                    m_t[i]  = nt;
                end
                if (alarm_set && v) m_al[i] = ld_sec;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                int t;
                t = m_t[i];
                check($sformatf("u%0d.hh", divs[i]), 32'(o_hh[i]), 32'(exp_hh(t, mode_24h)));
                check($sformatf("u%0d.mm", divs[i]), 32'(o_mm[i]), 32'(to_bcd((t / 60) % 60)));
                check($sformatf("u%0d.ss", divs[i]), 32'(o_ss[i]), 32'(to_bcd(t % 60)));
                check($sformatf("u%0d.pm", divs[i]), 32'(o_pm[i]), 32'(t >= 12 * 3600));
                check($sformatf("u%0d.load_err", divs[i]), 32'(o_le[i]), 32'(m_le[i]));
                check($sformatf("u%0d.day_wrap", divs[i]), 32'(o_dw[i]), 32'(m_dw[i]));
                check($sformatf("u%0d.alarm_hit", divs[i]), 32'(o_ah[i]), 32'(m_ah[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit e, input bit l, input bit a,
                         input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        @(posedge clk);
        #2;
        ena = e; load = l; alarm_set = a; ld_hh = h; ld_mm = m; ld_ss = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic tick_from(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        drive(1'b0, 1'b1, 1'b0, h, m, s);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        idle();
        @(negedge clk);
    endtask

    task automatic bad_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        drive(1'b0, 1'b1, 1'b0, h, m, s);
        idle();
        @(negedge clk);
        check("bad_load.err", 32'(o_le[0]), 32'h1);
        check("bad_load.time", {8'h0, o_hh[0], o_mm[0], o_ss[0]}, 32'h00123456);
    endtask

    initial begin
        logic [7:0] rh, rm, rs;
        int sel, sec;

        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst.hh12", 32'(o_hh[0]), 32'h12);
        check("rst.mmss", {o_mm[0], o_ss[0]}, 32'h0000);
        check("rst.pm", 32'(o_pm[0]), 32'h0);
        #1 mode_24h = 1'b1;
        #1 check("rst.hh24", 32'(o_hh[0]), 32'h00);
        @(posedge clk);
        #2 rst = 1'b0;
        chk_on = 1'b1;

        // rollover into pm and across midnight
        mode_24h = 1'b0;
        tick_from(8'h11, 8'h59, 8'h59);
        check("noon.hms", {8'h0, o_hh[0], o_mm[0], o_ss[0]}, 32'h00120000);
        check("noon.pm", 32'(o_pm[0]), 32'h1);
        tick_from(8'h23, 8'h59, 8'h59);
        check("midnight.hms", {8'h0, o_hh[0], o_mm[0], o_ss[0]}, 32'h00120000);
        check("midnight.pm", 32'(o_pm[0]), 32'h0);
        check("midnight.day_wrap", 32'(o_dw[0]), 32'h1);
        idle();
        @(negedge clk);
        check("midnight.day_wrap_drop", 32'(o_dw[0]), 32'h0);

        // hour-digit carries and 12h pm decode
        mode_24h = 1'b1;
        tick_from(8'h09, 8'h59, 8'h59);
        check("carry09", {8'h0, o_hh[0], o_mm[0], o_ss[0]}, 32'h00100000);
        tick_from(8'h19, 8'h59, 8'h59);
        check("carry19", {8'h0, o_hh[0], o_mm[0], o_ss[0]}, 32'h00200000);
        mode_24h = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 8'h13, 8'h05, 8'h00);
        idle();
        @(negedge clk);
        check("13h.hh12", 32'(o_hh[0]), 32'h01);
        check("13h.pm", 32'(o_pm[0]), 32'h1);

        // rejected loads leave time untouched
        mode_24h = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'h56);
        bad_load(8'h24, 8'h00, 8'h00);
        bad_load(8'h12, 8'h6A, 8'h00);
        bad_load(8'h12, 8'h60, 8'h00);

        // alarm: armed hit, disarmed silence, direct load onto alarm time
        alarm_arm = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 8'h07, 8'h30, 8'h00);
        tick_from(8'h07, 8'h29, 8'h59);
        check("alarm.hit", 32'(o_ah[0]), 32'h1);
        idle();
        @(negedge clk);
        check("alarm.hit_drop", 32'(o_ah[0]), 32'h0);
        alarm_arm = 1'b0;
        tick_from(8'h07, 8'h29, 8'h59);
        check("alarm.disarmed", 32'(o_ah[0]), 32'h0);
        alarm_arm = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8'h07, 8'h30, 8'h00);
        idle();
        @(negedge clk);
        check("alarm.load_no_hit", 32'(o_ah[0]), 32'h0);

        // prescaler by 3
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (6) drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        idle();
        @(negedge clk);
        check("div3.six_ena", 32'(o_ss[1]), 32'h02);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h10);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        idle();
        @(negedge clk);
        check("div3.load_wins", 32'(o_ss[1]), 32'h10);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        idle();
        @(negedge clk);
        check("div3.third_ena", 32'(o_ss[1]), 32'h11);

        // asynchronous reset mid-count
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        #1 rst = 1'b1;
        #1;
        check("async_rst.u1", {8'h0, o_hh[0], o_mm[0], o_ss[0]}, 32'h00000000);
        check("async_rst.u3", {8'h0, o_hh[1], o_mm[1], o_ss[1]}, 32'h00000000);
        check("async_rst.strobes", {o_le[0], o_dw[0], o_ah[0]}, 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom % 5);
            case (sel)
                0: begin
                    rh = 8'($urandom); rm = 8'($urandom); rs = 8'($urandom);
                end
                1: begin
                    rh = to_bcd(int'($urandom % 24));
                    rm = to_bcd(int'($urandom % 60));
                    rs = to_bcd(int'($urandom % 60));
                end
                2: begin
                    rh = 8'h23; rm = 8'h59; rs = to_bcd(55 + int'($urandom % 5));
                end
                3: begin
                    sec = (m_al[0] - int'($urandom % 4) + 86400) % 86400;
                    rh = to_bcd(sec / 3600); rm = to_bcd((sec / 60) % 60); rs = to_bcd(sec % 60);
                end
                default: begin
                    rh = ($urandom % 2 == 0) ? 8'h11 : 8'h12;
                    rm = 8'h59; rs = to_bcd(57 + int'($urandom % 3));
                end
            endcase
            drive(($urandom % 4) != 0, ($urandom % 12) == 0, ($urandom % 40) == 0, rh, rm, rs);
            mode_24h = 1'($urandom);
            if ($urandom % 50 == 0) alarm_arm = ~alarm_arm;
            if ($urandom % 700 == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        idle();
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
